// File: rtl/dual_acc_pkg.sv
// Shared types and arithmetic for the dual accumulator monitor.
//   state_e : hit/hold FSM states
//   acc_add : WIDTH-bounded add carrying the wrap/saturate rule
// Configuration macro: DUAL_ACC_SATURATE_EN
//   defined   -> sums above 2^WIDTH-1 clamp to 2^WIDTH-1
//   undefined -> sums wrap modulo 2^WIDTH
package dual_acc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Widest accumulator the helper supports; callers zero-extend into it.
  localparam int unsigned ACC_MAX_W = 32;

  // Sum is formed one bit wider than the operands so the carry out of a
  // WIDTH-bit add is visible before the wrap/clamp is applied.
  function automatic logic [ACC_MAX_W-1:0] acc_add(
    input logic [ACC_MAX_W-1:0] a,
    input logic [ACC_MAX_W-1:0] b,
    input int unsigned          width
  );
    logic [ACC_MAX_W:0] sum;
    logic [ACC_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{ACC_MAX_W{1'b0}}, 1'b1} << width) - {{ACC_MAX_W{1'b0}}, 1'b1};
`ifdef DUAL_ACC_SATURATE_EN
    if (sum > lim) begin
      sum = lim;
    end
`else
    sum = sum & lim;
`endif
    return sum[ACC_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/dual_acc_monitor_cmp.sv
// Threshold comparator bank for the dual accumulator monitor.
// All compares are unsigned at WIDTH bits; purely combinational.
// Ports:
//   x, y   : accumulator registers
//   z_ge   : x >= THRESH
//   z_nle  : !(x <= THRESH)
//   z_gt   : x > THRESH (identical to z_nle by construction)
//   z_eq   : x == THRESH or y == THRESH
module dual_acc_cmp #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned THRESH = 10
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             z_ge,
  output logic             z_nle,
  output logic             z_gt,
  output logic             z_eq
);

  localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

  always_comb begin
    z_ge  = (x >= THR);
    z_nle = !(x <= THR);
    z_gt  = (x > THR);
    z_eq  = (x == THR) || (y == THR);
  end

endmodule

// File: rtl/dual_acc_monitor.sv
// Coupled X/Y accumulator pair with threshold flags and a hit/hold FSM.
// An accepted update (add_valid && add_ready) either adds the operand to
// both registers (add < SMALL_LIM) or cross-updates: X += Y while
// X < X_LIM, Y <= old X. An update landing X or Y on THRESH sets the
// sticky hit and parks the FSM in HOLD until clr_hit.
// Configuration macro: DUAL_ACC_SATURATE_EN (clamp instead of wrap).
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   init      : synchronous reload (X=Y=INIT, cnt=0, hit=0, RUN)
//   add_valid : operand valid
//   add       : operand
//   add_ready : high in RUN, low in HOLD
//   clr_hit   : clears hit, HOLD -> RUN
//   x_out     : X register
//   y_out     : Y register
//   z_ge/z_nle/z_gt/z_eq : threshold flags from the current registers
//   hit       : sticky threshold hit
//   upd_cnt   : accepted-update count, saturating
module dual_acc_monitor
  import dual_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned THRESH    = 10,
  parameter int unsigned INIT      = 1,
  parameter int unsigned SMALL_LIM = 2,
  parameter int unsigned X_LIM     = 5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             add_valid,
  input  logic [WIDTH-1:0] add,
  output logic             add_ready,
  input  logic             clr_hit,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             z_ge,
  output logic             z_nle,
  output logic             z_gt,
  output logic             z_eq,
  output logic             hit,
  output logic [CNT_W-1:0] upd_cnt
);

  localparam logic [WIDTH-1:0] THR   = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] INI   = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] SMALL = WIDTH'(SMALL_LIM);
  localparam logic [WIDTH-1:0] XLIM  = WIDTH'(X_LIM);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] upd_x;
  logic [WIDTH-1:0] upd_y;
  logic [CNT_W-1:0] cnt;
  logic             hit_r;
  logic             accept;
  logic             upd_hit;

  // Candidate result of an update; both paths read pre-edge X and Y.
  always_comb begin
    upd_x = x;
    upd_y = y;
    if (add < SMALL) begin
      upd_x = WIDTH'(acc_add(ACC_MAX_W'(x), ACC_MAX_W'(add), WIDTH));
      upd_y = WIDTH'(acc_add(ACC_MAX_W'(y), ACC_MAX_W'(add), WIDTH));
    end else begin
      if (x < XLIM) begin
        upd_x = WIDTH'(acc_add(ACC_MAX_W'(x), ACC_MAX_W'(y), WIDTH));
      end
      upd_y = x;
    end
  end

  always_comb begin
    accept  = add_valid && add_ready && !init;
    upd_hit = (upd_x == THR) || (upd_y == THR);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state. clr_hit in RUN does not block an update, so a fresh
  // threshold hit on that same edge still enters HOLD.
  always_comb begin
    state_next = state;
    if (init) begin
      state_next = RUN;
    end else if (state == HOLD) begin
      state_next = clr_hit ? RUN : HOLD;
    end else if (accept && upd_hit) begin
      state_next = HOLD;
    end
  end

  // FSM: outputs
  always_comb begin
    add_ready = (state == RUN);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x     <= INI;
      y     <= INI;
      cnt   <= '0;
      hit_r <= 1'b0;
    end else if (init) begin
      x     <= INI;
      y     <= INI;
      cnt   <= '0;
      hit_r <= 1'b0;
    end else begin
      if (accept) begin
        x <= upd_x;
        y <= upd_y;
        if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
      end
      if (accept && upd_hit) begin
        hit_r <= 1'b1;
      end else if (clr_hit) begin
        hit_r <= 1'b0;
      end
    end
  end

  dual_acc_cmp #(
    .WIDTH  (WIDTH),
    .THRESH (THRESH)
  ) u_cmp (
    .x     (x),
    .y     (y),
    .z_ge  (z_ge),
    .z_nle (z_nle),
    .z_gt  (z_gt),
    .z_eq  (z_eq)
  );

  always_comb begin
    x_out   = x;
    y_out   = y;
    hit     = hit_r;
    upd_cnt = cnt;
  end

endmodule

// File: tb/tb_dual_acc_monitor.sv
// Scoreboard bench for dual_acc_monitor at WIDTH=4, THRESH=10, INIT=1.
// Each driven cycle pushes the model's expected outputs; the test tasks
// pop and compare after the following edge.
module tb_dual_acc_monitor;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       ge;
    logic       nle;
    logic       gt;
    logic       eq;
    logic       hit;
    logic       ready;
    logic [7:0] cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       add_valid;
  logic [3:0] add;
  logic       add_ready;
  logic       clr_hit;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic       z_ge, z_nle, z_gt, z_eq;
  logic       hit;
  logic [7:0] upd_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  obs_t        sbq[$];

  int unsigned mx, my, mc;
  bit          mh, mhold;

  always #5 clk = ~clk;

  dual_acc_monitor #(
    .WIDTH     (4),
    .THRESH    (10),
    .INIT      (1),
    .SMALL_LIM (2),
    .X_LIM     (5),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .add_valid (add_valid),
    .add       (add),
    .add_ready (add_ready),
    .clr_hit   (clr_hit),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_ge      (z_ge),
    .z_nle     (z_nle),
    .z_gt      (z_gt),
    .z_eq      (z_eq),
    .hit       (hit),
    .upd_cnt   (upd_cnt)
  );

  function automatic int unsigned m_add(int unsigned a, int unsigned b);
    int unsigned s;
    s = a + b;
`ifdef DUAL_ACC_SATURATE_EN
    if (s > 15) s = 15;
`else
    s = s % 16;
`endif
    return s;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.x     = mx[3:0];
    o.y     = my[3:0];
    o.ge    = (mx >= 10);
    o.nle   = (mx > 10);
    o.gt    = (mx > 10);
    o.eq    = (mx == 10) || (my == 10);
    o.hit   = mh;
    o.ready = !mhold;
    o.cnt   = mc[7:0];
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x     = x_out;
    o.y     = y_out;
    o.ge    = z_ge;
    o.nle   = z_nle;
    o.gt    = z_gt;
    o.eq    = z_eq;
    o.hit   = hit;
    o.ready = add_ready;
    o.cnt   = upd_cnt;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("x=%0d y=%0d ge=%0b nle=%0b gt=%0b eq=%0b hit=%0b rdy=%0b cnt=%0d",
                     o.x, o.y, o.ge, o.nle, o.gt, o.eq, o.hit, o.ready, o.cnt);
  endfunction

  task automatic model_reset();
    mx = 1; my = 1; mc = 0; mh = 0; mhold = 0;
  endtask

  // Drive one cycle, advance the model, queue the expectation, and leave
  // the bench #1 after the active edge ready for sampling.
  task automatic step(bit v, int unsigned a, bit c, bit in);
    bit          acc;
    int unsigned nx, ny;
    add_valid = v;
    add       = a[3:0];
    clr_hit   = c;
    init      = in;
    if (in) begin
      model_reset();
    end else begin
      acc = v && !mhold;
      if (mhold && c) mhold = 0;
      if (c) mh = 0;
      if (acc) begin
        if (a < 2) begin
          nx = m_add(mx, a);
          ny = m_add(my, a);
        end else begin
          nx = (mx < 5) ? m_add(mx, my) : mx;
          ny = mx;
        end
        mx = nx;
        my = ny;
        if (mc < 255) mc++;
        if (nx == 10 || ny == 10) begin
          mh = 1;
          mhold = 1;
        end
      end
    end
    sbq.push_back(model_obs());
    @(posedge clk);
    #1;
    add_valid = 0;
    clr_hit   = 0;
    init      = 0;
  endtask

  task automatic pulse_reset();
    reset = 0;
    model_reset();
    #3;
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, g;
    reset = 0; init = 0; add_valid = 0; add = 0; clr_hit = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    sbq.push_back(model_obs());
    #1;
    e = sbq.pop_front(); g = dut_obs(); n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %s exp %s", fmt(g), fmt(e));
    end
  endtask

  task automatic test_accumulate();
    obs_t e, g;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      e = sbq.pop_front(); g = dut_obs(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL acc_add1[%0d]: got %s exp %s", i, fmt(g), fmt(e));
      end
    end
    step(1, 0, 0, 0);
    e = sbq.pop_front(); g = dut_obs(); n_checks++;
    if (g !== e || g.x !== 4'd4 || g.cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL acc_add0: got %s exp %s", fmt(g), fmt(e));
    end
  endtask

  task automatic test_cross();
    obs_t e, g;
    int unsigned ex[4] = '{2, 3, 5, 5};
    int unsigned ey[4] = '{1, 2, 3, 5};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 3, 0, 0);
      e = sbq.pop_front(); g = dut_obs(); n_checks++;
      if (g !== e || g.x !== ex[i][3:0] || g.y !== ey[i][3:0]) begin
        n_fail++;
        $display("FAIL cross[%0d]: got %s exp %s", i, fmt(g), fmt(e));
      end
      n_checks++;
      if (z_gt !== z_nle) begin
        n_fail++;
        $display("FAIL gt_vs_nle[%0d]: got gt=%0b required nle=%0b", i, z_gt, z_nle);
      end
    end
  endtask

  task automatic test_hit_hold();
    obs_t e, g;
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, 0);
      e = sbq.pop_front(); g = dut_obs(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL climb[%0d]: got %s exp %s", i, fmt(g), fmt(e));
      end
    end
    n_checks++;
    if (!(hit === 1'b1 && z_eq === 1'b1 && z_ge === 1'b1 && add_ready === 1'b0)) begin
      n_fail++;
      $display("FAIL hit_flags: got hit=%0b eq=%0b ge=%0b rdy=%0b exp 1 1 1 0",
               hit, z_eq, z_ge, add_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      e = sbq.pop_front(); g = dut_obs(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL hold_freeze[%0d]: got %s exp %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_clr_and_width();
    obs_t e, g;
    step(1, 1, 1, 0);
    e = sbq.pop_front(); g = dut_obs(); n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL clr_drop: got %s exp %s", fmt(g), fmt(e));
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0);
      e = sbq.pop_front(); g = dut_obs(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL post_clr[%0d]: got %s exp %s", i, fmt(g), fmt(e));
      end
    end
    step(1, 1, 0, 0);
    e = sbq.pop_front(); g = dut_obs(); n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL overflow: got %s exp %s", fmt(g), fmt(e));
    end
  endtask

  task automatic test_async_reset_init();
    obs_t e, g;
    step(1, 0, 0, 1);
    void'(sbq.pop_front());
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, 0);
      void'(sbq.pop_front());
    end
    n_checks++;
    if (add_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL enter_hold: got rdy=%0b exp 0", add_ready);
    end
    #2;
    reset = 0;
    model_reset();
    sbq.push_back(model_obs());
    #1;
    e = sbq.pop_front(); g = dut_obs(); n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL async_reset_hold: got %s exp %s", fmt(g), fmt(e));
    end
    reset = 1;
    @(posedge clk);
    #1;
    step(1, 3, 0, 0);
    void'(sbq.pop_front());
    step(1, 1, 0, 0);
    void'(sbq.pop_front());
    step(1, 1, 0, 1);
    e = sbq.pop_front(); g = dut_obs(); n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL init_run: got %s exp %s", fmt(g), fmt(e));
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_cross();
    test_hit_hold();
    test_clr_and_width();
    test_async_reset_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
